// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Word-organised data memory behind a single-request, fixed-latency
// load/store controller. One request is accepted while idle, the access is
// performed LAT edges later, and a one-cycle response strobe follows.
// Stores are byte-lane merges; loads extract a byte/half/word and extend it.
//
// Parameters
//   DEPTH    memory size in 32-bit words (power of two, 16..65536)
//   LAT      access latency in cycles (1..15)
//
// Ports
//   clk      in   1   sole clock, all state changes on posedge
//   reset    in   1   synchronous active-high reset (clears memory too)
//   req      in   1   request valid, sampled only while ready=1
//   we       in   1   1 = store, 0 = load
//   size     in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//   sign_ext in   1   load extension: 1 sign, 0 zero
//   addr     in  32   byte address
//   wd       in  32   right-aligned store data
//   pc       in  32   instruction address (trace only)
//   ready    out  1   controller idle and not in reset
//   rvalid   out  1   one-cycle response strobe
//   rd       out 32   load result or merged stored word
//   err      out  1   request failed, qualified by rvalid
//
// Build option
//   DM_TRACE_EN  when defined, every successful store prints
//                "<time>@<pc>: *<addr> <= <merged word>" at its access edge.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH = 4096,
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rd,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    logic        accept_s;
    logic        access_s;
    logic        err_s;
    logic [AW-1:0] idx_s;
    logic [31:0] old_word_s;
    logic [31:0] merged_s;
    logic [31:0] loaded_s;

    // Byte-lane merge of right-aligned store data into the existing word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_d,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = old_w;
        case (sz)
            2'b00: begin
                case (off)
                    2'b00:   r[7:0]   = new_d[7:0];
                    2'b01:   r[15:8]  = new_d[7:0];
                    2'b10:   r[23:16] = new_d[7:0];
                    default: r[31:24] = new_d[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = new_d[15:0];
                end else begin
                    r[15:0] = new_d[15:0];
                end
            end
            2'b10:   r = new_d;
            default: r = old_w;
        endcase
        return r;
    endfunction

    // Lane select plus sign/zero extension for loads.
    function automatic logic [31:0] load_word(input logic [31:0] w,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off,
                                              input logic        se);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{se & b[7]}}, b};
            2'b01:   r = {{16{se & h[15]}}, h};
            2'b10:   r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign ready    = (state_q == S_IDLE) && !reset;
    assign rvalid   = (state_q == S_RESP);
    assign rd       = rd_q;
    assign err      = err_q;
    assign accept_s = req && ready;
    assign access_s = (state_q == S_BUSY) && (cnt_q == 4'd1);

    // Error classification of the captured request; upper address bits
    // beyond the memory window are an error, not an alias.
    assign err_s = (size_q == 2'b11) ||
                   ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) ||
                   (|addr_q[31:AW+2]);

    assign idx_s      = addr_q[AW+1:2];
    assign old_word_s = mem_q[idx_s];
    assign merged_s   = merge_word(old_word_s, wd_q, size_q, addr_q[1:0]);
    assign loaded_s   = load_word(old_word_s, size_q, addr_q[1:0], sext_q);

    // Next-state and latency counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_BUSY;
                    cnt_d   = 4'(LAT);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM, request capture and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_s) begin
                we_q   <= we;
                size_q <= size;
                sext_q <= sign_ext;
                addr_q <= addr;
                wd_q   <= wd;
            end
            if (access_s) begin
                err_q <= err_s;
                if (err_s) begin
                    rd_q <= 32'd0;
                end else if (we_q) begin
                    rd_q <= merged_s;
                end else begin
                    rd_q <= loaded_s;
                end
            end
        end
    end

    // Memory array: cleared on reset, written only by error-free stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (access_s && we_q && !err_s) begin
            mem_q[idx_s] <= merged_s;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] pc_q;

    // Instruction address kept only for the store trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'd0;
        end else if (accept_s) begin
            pc_q <= pc;
        end
    end

    // Store trace at the access edge.
    always_ff @(posedge clk) begin
        if (!reset && access_s && we_q && !err_s) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, merged_s);
        end
    end
`else
    // pc only feeds the trace, which is absent in this build.
    logic unused_pc_s;
    assign unused_pc_s = ^pc;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst1, rst3;
    logic        req1, req3;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr, wd, pc;
    logic        rdy1, rdy3, rv1, rv3, er1, er3;
    logic [31:0] rd1, rd3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    data_mem_ctrl #(.DEPTH(4096), .LAT(1)) dut1 (
        .clk(clk), .reset(rst1), .req(req1), .we(we), .size(size),
        .sign_ext(sext), .addr(addr), .wd(wd), .pc(pc),
        .ready(rdy1), .rvalid(rv1), .rd(rd1), .err(er1)
    );

    data_mem_ctrl #(.DEPTH(4096), .LAT(3)) dut3 (
        .clk(clk), .reset(rst3), .req(req3), .we(we), .size(size),
        .sign_ext(sext), .addr(addr), .wd(wd), .pc(pc),
        .ready(rdy3), .rvalid(rv3), .rd(rd3), .err(er3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe pops one expectation.
    always @(negedge clk) begin
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("lat1 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("lat1 rd", rd1, e1.rd);
                chk("lat1 err", {31'd0, er1}, {31'd0, e1.err});
                chk("lat1 cycle", cyc, e1.cyc);
            end
        end
        if (rv3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("lat3 unexpected rvalid", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                chk("lat3 rd", rd3, e3.rd);
                chk("lat3 err", {31'd0, er3}, {31'd0, e3.err});
                chk("lat3 cycle", cyc, e3.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit sel3, input bit push, input logic w, input logic [1:0] sz,
                         input logic se, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] erd, input logic eerr);
        int   lat;
        bit   got;
        exp_t x;
        lat  = sel3 ? 3 : 1;
        we   = w;
        size = sz;
        sext = se;
        addr = a;
        wd   = d;
        pc   = 32'h0000_1000 + a;
        if (sel3) req3 = 1'b1; else req1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if ((sel3 ? rdy3 : rdy1) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("accept timeout", 32'd0, 32'd1);
            req1 = 1'b0;
            req3 = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (push) begin
                x.rd  = erd;
                x.err = eerr;
                x.cyc = cyc + lat;
                if (sel3) q3.push_back(x); else q1.push_back(x);
            end
            @(negedge clk);
            req1 = 1'b0;
            req3 = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0 && q3.size() == 0) break;
            @(negedge clk);
        end
        chk("queues drained", q1.size() + q3.size(), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst1 = 1'b1; rst3 = 1'b1; req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'd0; wd = 32'd0; pc = 32'd0;

        // Reset state.
        @(negedge clk);
        chk("ready1 in reset", {31'd0, rdy1}, 32'd0);
        chk("ready3 in reset", {31'd0, rdy3}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rd1 reset", rd1, 32'd0);
        chk("err1 reset", {31'd0, er1}, 32'd0);
        chk("rvalid3 reset", {31'd0, rv3}, 32'd0);
        rst1 = 1'b0; rst3 = 1'b0;
        #1;
        chk("ready1 after reset", {31'd0, rdy1}, 32'd1);
        chk("ready3 after reset", {31'd0, rdy3}, 32'd1);
        @(negedge clk);

        // LAT=1 directed vectors: w, size, sext, addr, wd -> rd, err.
        issue(0, 1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h1234_5678, 1'b0);
        issue(0, 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_5678, 1'b0);
        issue(0, 1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'h1234_AB78, 1'b0);
        issue(0, 1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         32'hFFFF_FFAB, 1'b0);
        issue(0, 1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         32'h0000_00AB, 1'b0);
        issue(0, 1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 32'h8001_AB78, 1'b0);
        issue(0, 1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         32'hFFFF_8001, 1'b0);
        issue(0, 1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h0000_8001, 1'b0);
        issue(0, 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8001_AB78, 1'b0);
        issue(0, 1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0);
        issue(0, 1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'hFFFF_AB78, 1'b0);
        issue(0, 1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0,         32'h0,         1'b1);
        issue(0, 1, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5555, 32'h0,         1'b1);
        issue(0, 1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,         1'b1);
        issue(0, 1, 1'b1, 2'b10, 1'b0, 32'h4010, 32'hFFFF_FFFF, 32'h0,       1'b1);
        issue(0, 1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0,       32'h0,         1'b1);
        issue(0, 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8001_AB78, 1'b0);
        drain();

        // LAT=3: store, then a request held high across a whole transaction.
        issue(1, 1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        drain();
        we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10; wd = 32'd0;
        req3 = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        q3.push_back('{32'h0BAD_F00D, 1'b0, k + 3});
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            if (j == 2) chk("ready3 busy", {31'd0, rdy3}, 32'd0);
            if (j == 4) chk("ready3 idle after resp", {31'd0, rdy3}, 32'd1);
            if (j == 5) q3.push_back('{32'h0BAD_F00D, 1'b0, cyc + 3});
        end
        @(negedge clk);
        req3 = 1'b0;
        drain();

        // LAT=3: reset during BUSY aborts the store; reset clears memory.
        issue(1, 1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0);
        drain();
        issue(1, 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
        rst3 = 1'b1;
        #1;
        chk("ready3 during reset", {31'd0, rdy3}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("ready3 after abort", {31'd0, rdy3}, 32'd1);
        repeat (6) @(negedge clk);
        issue(1, 1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0);
        issue(1, 1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0000_0000, 1'b0);
        issue(1, 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
